// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states,
// wait-state bound and access legality helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned WAIT_CYCLES_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
      default:                        f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: f3_misaligned = off[0];
      F3_W:        f3_misaligned = |off;
      default:     f3_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: load extraction/extension and store lane merge
// into the currently stored word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rd_word >> {byte_off, 3'b000};
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      F3_W:    load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_word = rd_word;
    case (funct3)
      F3_B:    store_word[{byte_off, 3'b000} +: 8]        = wdata[7:0];
      F3_H:    store_word[{byte_off[1], 4'b0000} +: 16]   = wdata[15:0];
      F3_W:    store_word = wdata;
      default: store_word = rd_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with configurable wait states.
// Define DMEM_RANGE_CHECK_EN to reject addresses beyond DEPTH_WORDS instead of wrapping.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > WAIT_CYCLES_MAX) ?
                                     4'(WAIT_CYCLES_MAX) : 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_f3;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_f3;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        acc_err;
  logic [31:0] rd_word;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_ready = rst & (state == ST_IDLE);
  assign accept    = req_valid & req_ready;

  // With zero wait states the commit happens on the acceptance edge, so the
  // access is decoded straight from the request inputs while still in IDLE.
  assign cur_write = (state == ST_IDLE) ? req_write  : lat_write;
  assign cur_addr  = (state == ST_IDLE) ? req_addr   : lat_addr;
  assign cur_wdata = (state == ST_IDLE) ? req_wdata  : lat_wdata;
  assign cur_f3    = (state == ST_IDLE) ? req_funct3 : lat_f3;
  assign idx       = cur_addr[AW+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  assign in_range = ({2'b00, cur_addr[31:2]} < 32'(DEPTH_WORDS));
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |cur_addr[31:AW+2];
  assign in_range = 1'b1;
`endif

  assign acc_err = ~f3_legal(cur_f3) | f3_misaligned(cur_f3, cur_addr[1:0]) | ~in_range;
  assign commit  = ((state == ST_IDLE) && accept && (WAIT_LOAD == 4'd0)) ||
                   ((state == ST_WAIT) && (wait_cnt == 4'd1));
  assign rd_word = mem[idx];

  dmem_lane_align u_lane_align (
    .funct3     (cur_f3),
    .byte_off   (cur_addr[1:0]),
    .rd_word    (rd_word),
    .wdata      (cur_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Storage has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (commit && cur_write && !acc_err) begin
      mem[idx] <= store_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_f3    <= req_funct3;
            wait_cnt  <= WAIT_LOAD;
            state     <= (WAIT_LOAD == 4'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (commit) begin
      rsp_valid <= 1'b1;
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || cur_write) ? '0 : load_data;
    end else if ((state == ST_RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-addressed reference model and a
// per-cycle compare process.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAITC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem_b [DEPTH*4];
  bit          pending = 1'b0;
  time         acc_time = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: bytes in a flat array; sizes, alignment and extension by arithmetic.
  task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, output logic [31:0] rd, output logic e);
    int unsigned size;
    bit          legal;
    longint      v;
    int unsigned base;
    legal = 1'b1;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default: begin legal = 1'b0; size = 1; end
    endcase
    e = !legal || ((a % size) != 0);
`ifdef DMEM_RANGE_CHECK_EN
    if ((a >> 2) >= DEPTH) e = 1'b1;
`endif
    rd = '0;
    if (!e) begin
      base = ((a >> 2) % DEPTH) * 4 + (a % 4);
      if (w) begin
        for (int i = 0; i < int'(size); i++) mem_b[base + i] = 8'(d >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < int'(size); i++) v += longint'(mem_b[base + i]) << (8 * i);
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
          v -= (longint'(1) << (8 * size));
        rd = 32'(v);
      end
    end
  endtask

  task automatic compare_loop();
    int age;
    bit exp_v;
    forever begin
      @(negedge clk);
      if (rst) begin
        age   = pending ? int'(($time - acc_time) / 10) + 1 : 0;
        exp_v = pending && (age >= int'(WAITC) + 1);
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
        chk("req_ready", {31'b0, req_ready}, {31'b0, !pending});
        if (rsp_valid && exp_v) begin
          chk("rsp_rdata", rsp_rdata, exp_rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        end
      end
    end
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input bit apply, output int waits);
    req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3; req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      acc_time = $time;
      if (apply) model(w, a, d, f3, exp_rdata, exp_err);
      pending = 1'b1;
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic complete();
    rsp_ready = 1'b1;
    @(posedge clk);
    pending = 1'b0;
    #1 rsp_ready = 1'b0;
  endtask

  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, output logic [31:0] rd, output logic e,
                      output int lat);
    int waits;
    issue(w, a, d, f3, 1'b1, waits);
    wait_valid(lat);
    rd = rsp_rdata;
    e  = rsp_err;
    complete();
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          waits;

    fork
      compare_loop();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("ready_after_release", {31'b0, req_ready}, 32'd1);

    xact(1'b1, 32'h10, 32'hDEADBEEF, F3_W, rd, e, lat);
    chk("sw_err", {31'b0, e}, 32'd0);
    chk("sw_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, F3_W, rd, e, lat);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err", {31'b0, e}, 32'd0);
    chk("lw_latency", lat, 32'd3);

    xact(1'b1, 32'h13, 32'h80, F3_B, rd, e, lat);
    xact(1'b0, 32'h13, 32'h0, F3_B, rd, e, lat);
    chk("lb_sign", rd, 32'hFFFFFF80);
    xact(1'b0, 32'h13, 32'h0, F3_BU, rd, e, lat);
    chk("lbu_zero", rd, 32'h00000080);
    xact(1'b0, 32'h10, 32'h0, F3_W, rd, e, lat);
    chk("lw_after_sb", rd, 32'h80ADBEEF);

    xact(1'b0, 32'h11, 32'h0, F3_H, rd, e, lat);
    chk("lh_misalign_err", {31'b0, e}, 32'd1);
    chk("lh_misalign_rdata", rd, 32'd0);
    xact(1'b1, 32'h12, 32'h12345678, F3_W, rd, e, lat);
    chk("sw_misalign_err", {31'b0, e}, 32'd1);
    xact(1'b0, 32'h10, 32'h0, 3'b011, rd, e, lat);
    chk("illegal_f3_err", {31'b0, e}, 32'd1);
    chk("illegal_f3_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, F3_W, rd, e, lat);
    chk("lw_after_errors", rd, 32'h80ADBEEF);

    xact(1'b1, 32'h12, 32'h0000CAFE, F3_H, rd, e, lat);
    xact(1'b0, 32'h10, 32'h0, F3_W, rd, e, lat);
    chk("lw_after_sh", rd, 32'hCAFEBEEF);
    xact(1'b0, 32'h12, 32'h0, F3_H, rd, e, lat);
    chk("lh_sign", rd, 32'hFFFFCAFE);
    xact(1'b0, 32'h12, 32'h0, F3_HU, rd, e, lat);
    chk("lhu_zero", rd, 32'h0000CAFE);

    xact(1'b1, 32'h20, 32'h11223344, F3_W, rd, e, lat);
    xact(1'b1, 32'h0, 32'hA5A55A5A, F3_W, rd, e, lat);

    // Back-pressure: hold rsp_ready low while the next request waits with req_valid high.
    issue(1'b0, 32'h10, 32'h0, F3_W, 1'b1, waits);
    wait_valid(lat);
    req_write = 1'b0; req_addr = 32'h0; req_wdata = '0; req_funct3 = F3_W; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rdata", rsp_rdata, 32'hCAFEBEEF);
      chk("stall_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    complete();
    issue(1'b0, 32'h0, 32'h0, F3_W, 1'b1, waits);
    chk("next_accept_delay", waits, 32'd0);
    wait_valid(lat);
    chk("lw_word0", rsp_rdata, 32'hA5A55A5A);
    complete();

    // Reset during the wait states of a store: the store must be dropped.
    issue(1'b1, 32'h20, 32'h1, F3_W, 1'b0, waits);
    @(negedge clk);
    #2 rst = 1'b0;
    pending = 1'b0;
    #1;
    chk("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midreset_rsp_rdata", rsp_rdata, 32'd0);
    chk("midreset_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("midreset_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("ready_after_midreset", {31'b0, req_ready}, 32'd1);
    xact(1'b0, 32'h20, 32'h0, F3_W, rd, e, lat);
    chk("word20_kept", rd, 32'h11223344);

    xact(1'b0, 32'h400, 32'h0, F3_W, rd, e, lat);
`ifdef DMEM_RANGE_CHECK_EN
    chk("range_err", {31'b0, e}, 32'd1);
    chk("range_rdata", rd, 32'd0);
`else
    chk("wrap_err", {31'b0, e}, 32'd0);
    chk("wrap_rdata", rd, 32'hA5A55A5A);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states between acceptance and commit (0..15).
REQ-003 SHALL have port clk, input, 1, meaning single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, meaning initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1, meaning responder accepts a request this cycle.
REQ-007 SHALL have port req_write, input, 1, meaning 1 for store, 0 for load.
REQ-008 SHALL have port req_addr, input, 32, meaning byte address.
REQ-009 SHALL have port req_wdata, input, 32, meaning store data, LSB-aligned.
REQ-010 SHALL have port req_funct3, input, 3, meaning RV32I access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 SHALL have port rsp_valid, output, 1, meaning response available.
REQ-012 SHALL have port rsp_ready, input, 1, meaning initiator takes the response.
REQ-013 SHALL have port rsp_rdata, output, 32, meaning load result, sign- or zero-extended; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1, meaning access was rejected (misaligned, illegal funct3, or out of range).

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; when WAIT_CYCLES=0, IDLE -> RESP directly.
REQ-016 SHALL drive req_ready=1 only in IDLE; acceptance = req_valid & req_ready; write, addr, wdata and funct3 SHALL be latched at acceptance.
REQ-017 SHALL load a down-counter with WAIT_CYCLES at acceptance, decrement it once per WAIT cycle, and leave WAIT when it reaches 1.
REQ-018 SHALL commit the access (array read or byte-lane write) on the edge entering RESP; rsp_valid SHALL rise WAIT_CYCLES+1 cycles after acceptance.
REQ-019 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-020 SHALL accept no new request in the cycle rsp_ready completes; the earliest next acceptance is the following cycle (IDLE).
REQ-021 SHALL flag misalignment as H/HU with addr[0]=1 or W with addr[1:0]!=0; funct3 011, 110 or 111 is illegal.
REQ-022 SHALL, on an erroring access, leave storage unchanged, set rsp_err=1 and drive rsp_rdata=0.
REQ-023 SHALL write SB to one lane from addr[1:0] and SH to lanes {1,0} or {3,2}; other bytes are preserved.
REQ-024 SHALL extend B/H loads by sign, BU/HU by zero, and return W loads unchanged.
REQ-025 SHALL index storage with addr[log2(DEPTH_WORDS)+1:2].

Reset
REQ-026 SHALL, while rst=0, force state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0 and req_ready=0; req_ready SHALL be 1 in the first cycle after release.
REQ-027 SHALL drop a request that is mid-WAIT when rst is asserted, with no storage write.
REQ-028 SHALL retain storage contents across reset.

Configuration
REQ-029 SHALL, with DMEM_RANGE_CHECK_EN defined, treat an address with addr[31:2] >= DEPTH_WORDS as an error per REQ-022.
REQ-030 SHALL, without DMEM_RANGE_CHECK_EN, wrap such addresses modulo DEPTH_WORDS with no error.

Structure
REQ-031 SHALL place the funct3 encodings, the state enum and the WAIT_CYCLES bound in shared package dmem_pkg.
REQ-032 SHALL put load extension and store lane merge in sub-module dmem_lane_align, which is purely combinational.

Verification
REQ-033 SHALL cover: SW 0xDEADBEEF to addr 0x10, then LW 0x10 with WAIT_CYCLES=2 -> rdata 0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after acceptance.
REQ-034 SHALL cover: SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80 and LBU 0x13 -> 0x00000080; word 0x10 reads 0x80ADBEEF.
REQ-035 SHALL cover: LH 0x11 and SW 0x12 -> rsp_err=1, rdata 0; a subsequent LW 0x10 returns its value unchanged.
REQ-036 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid and rdata stable, req_ready=0 throughout; req_valid held high during this is accepted one cycle after rsp_ready.
REQ-037 SHALL cover: rst asserted mid-WAIT of SW 0x1 to 0x20 -> outputs reset immediately and word 0x20 keeps its old value.
REQ-038 SHALL cover: LW 0x400 with DEPTH_WORDS=256 -> rsp_err=1 with DMEM_RANGE_CHECK_EN, and the same data as word 0x0 without it.
